dsn_scheduler: RTL and testbench

DSN_SCHEDULER -- requirements
Module: dsn_scheduler

---
 rtl/dsn_scheduler.sv | 163 ++++++++++++++++
 tb/tb_dsn_scheduler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsn_scheduler.sv
// rtl/dsn_scheduler.sv - time-multiplexed neuron scheduler for a shared DSN datapath
//
// Holds one 13-bit membrane value per virtual neuron and time-shares a single
// external datapath between them. A synaptic request takes five cycles
// (IDLE->ISSUE->W1->W2->DONE); a tick runs a leak sweep over all neurons.
//
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   io_in_*               synaptic request handshake (nid, 9-bit vpre)
//   io_vth                shared firing threshold
//   io_tick               timestep boundary pulse, requests a leak sweep
//   io_dsn_*              operands to / results from the external datapath
//   io_spike_valid/nid    one-cycle spike event
//   io_busy               scheduler not idle
//   io_timestep           completed leak sweeps (mod 256)
//   io_tick_overrun       sticky flag: a tick was dropped
module dsn_scheduler #(
    parameter int NUM_NEURONS = 8,
    localparam int NID_W = $clog2(NUM_NEURONS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [NID_W-1:0] io_in_nid,
    input  logic [8:0]       io_in_vpre,
    input  logic [12:0]      io_vth,
    input  logic             io_tick,
    output logic [8:0]       io_dsn_vpre,
    output logic [12:0]      io_dsn_vleak_in,
    output logic [12:0]      io_dsn_vth,
    input  logic [12:0]      io_dsn_vleak_out,
    input  logic             io_dsn_spike,
    output logic             io_spike_valid,
    output logic [NID_W-1:0] io_spike_nid,
    output logic             io_busy,
    output logic [7:0]       io_timestep,
    output logic             io_tick_overrun
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] W1    = 3'd2;
    localparam logic [2:0] W2    = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] LEAK  = 3'd5;

    logic [2:0]       fsm_q, fsm_d;
    logic [NID_W-1:0] nid_q, nid_d;
    logic [NID_W-1:0] sweep_q, sweep_d;
    logic [12:0]      state_q [NUM_NEURONS];
    logic [12:0]      state_d [NUM_NEURONS];
    logic             tick_pending_q, tick_pending_d;
    logic [7:0]       timestep_q, timestep_d;
    logic             overrun_q, overrun_d;
    logic             spike_valid_q, spike_valid_d;
    logic [NID_W-1:0] spike_nid_q, spike_nid_d;
    logic [8:0]       dsn_vpre_q, dsn_vpre_d;
    logic [12:0]      dsn_vleak_q, dsn_vleak_d;
    logic             accept;

    // A tick arriving this very cycle already blocks new requests, so the
    // sweep wins over a simultaneous request.
    assign io_in_ready     = reset && (fsm_q == IDLE) && !tick_pending_q && !io_tick;
    assign accept          = io_in_valid && io_in_ready;
    assign io_dsn_vth      = io_vth;
    assign io_dsn_vpre     = dsn_vpre_q;
    assign io_dsn_vleak_in = dsn_vleak_q;
    assign io_spike_valid  = spike_valid_q;
    assign io_spike_nid    = spike_nid_q;
    assign io_busy         = (fsm_q != IDLE);
    assign io_timestep     = timestep_q;
    assign io_tick_overrun = overrun_q;

    always_comb begin
        fsm_d          = fsm_q;
        nid_d          = nid_q;
        sweep_d        = sweep_q;
        state_d        = state_q;
        tick_pending_d = tick_pending_q | io_tick;
        timestep_d     = timestep_q;
        overrun_d      = overrun_q;
        spike_valid_d  = 1'b0;
        spike_nid_d    = spike_nid_q;
        dsn_vpre_d     = dsn_vpre_q;
        dsn_vleak_d    = dsn_vleak_q;

        // Only one sweep can be queued; any further tick is lost.
        if (io_tick && (tick_pending_q || fsm_q == LEAK)) begin
            overrun_d = 1'b1;
        end

        case (fsm_q)
            IDLE: begin
                if (tick_pending_q || io_tick) begin
                    fsm_d   = LEAK;
                    sweep_d = '0;
                end else if (accept) begin
                    fsm_d       = ISSUE;
                    nid_d       = io_in_nid;
                    dsn_vpre_d  = io_in_vpre;
                    // The membrane value cannot change while the op is in
                    // flight, so a registered copy stays valid until DONE.
                    dsn_vleak_d = state_q[io_in_nid];
                end
            end
            ISSUE: fsm_d = W1;
            W1:    fsm_d = W2;
            W2:    fsm_d = DONE;
            DONE: begin
                state_d[nid_q] = io_dsn_spike ? 13'd0 : io_dsn_vleak_out;
                spike_valid_d  = io_dsn_spike;
                if (io_dsn_spike) begin
                    spike_nid_d = nid_q;
                end
                dsn_vpre_d  = '0;
                dsn_vleak_d = '0;
                fsm_d       = IDLE;
            end
            LEAK: begin
                state_d[sweep_q] = state_q[sweep_q] - (state_q[sweep_q] >> 3);
                sweep_d          = sweep_q + 1'b1;
                if (sweep_q == NID_W'(NUM_NEURONS - 1)) begin
                    tick_pending_d = 1'b0;
                    timestep_d     = timestep_q + 8'd1;
                    fsm_d          = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fsm_q          <= IDLE;
            nid_q          <= '0;
            sweep_q        <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                state_q[i] <= '0;
            end
            tick_pending_q <= 1'b0;
            timestep_q     <= '0;
            overrun_q      <= 1'b0;
            spike_valid_q  <= 1'b0;
            spike_nid_q    <= '0;
            dsn_vpre_q     <= '0;
            dsn_vleak_q    <= '0;
        end else begin
            fsm_q          <= fsm_d;
            nid_q          <= nid_d;
            sweep_q        <= sweep_d;
            state_q        <= state_d;
            tick_pending_q <= tick_pending_d;
            timestep_q     <= timestep_d;
            overrun_q      <= overrun_d;
            spike_valid_q  <= spike_valid_d;
            spike_nid_q    <= spike_nid_d;
            dsn_vpre_q     <= dsn_vpre_d;
            dsn_vleak_q    <= dsn_vleak_d;
        end
    end

endmodule

// File: tb/tb_dsn_scheduler.sv
// tb/tb_dsn_scheduler.sv - self-checking bench for dsn_scheduler
module tb_dsn_scheduler;

    logic        clock;
    logic        reset;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [2:0]  io_in_nid;
    logic [8:0]  io_in_vpre;
    logic [12:0] io_vth;
    logic        io_tick;
    logic [8:0]  io_dsn_vpre;
    logic [12:0] io_dsn_vleak_in;
    logic [12:0] io_dsn_vth;
    logic [12:0] io_dsn_vleak_out;
    logic        io_dsn_spike;
    logic        io_spike_valid;
    logic [2:0]  io_spike_nid;
    logic        io_busy;
    logic [7:0]  io_timestep;
    logic        io_tick_overrun;

    dsn_scheduler #(.NUM_NEURONS(8)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_in_valid      (io_in_valid),
        .io_in_ready      (io_in_ready),
        .io_in_nid        (io_in_nid),
        .io_in_vpre       (io_in_vpre),
        .io_vth           (io_vth),
        .io_tick          (io_tick),
        .io_dsn_vpre      (io_dsn_vpre),
        .io_dsn_vleak_in  (io_dsn_vleak_in),
        .io_dsn_vth       (io_dsn_vth),
        .io_dsn_vleak_out (io_dsn_vleak_out),
        .io_dsn_spike     (io_dsn_spike),
        .io_spike_valid   (io_spike_valid),
        .io_spike_nid     (io_spike_nid),
        .io_busy          (io_busy),
        .io_timestep      (io_timestep),
        .io_tick_overrun  (io_tick_overrun)
    );

    // Stand-in datapath: vleak_out = vleak_in + vpre[7:0]; fire path spikes when that reaches vth.
    logic [12:0] dp_sum;
    assign dp_sum           = io_dsn_vleak_in + {5'd0, io_dsn_vpre[7:0]};
    assign io_dsn_vleak_out = dp_sum;
    assign io_dsn_spike     = io_dsn_vpre[8] && (dp_sum >= io_dsn_vth);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [12:0] m_state [8];
    int          m_ts  = 0;
    logic        m_ovr = 1'b0;

    typedef struct {
        logic [2:0]  nid;
        logic [8:0]  vpre;
        logic [12:0] vth;
        logic        spike;
        logic [12:0] state;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [13:0] predict(input logic [2:0] nid, input logic [8:0] vpre,
                                            input logic [12:0] vth);
        int sum;
        sum = (int'(m_state[nid]) + int'(vpre[7:0])) % 8192;
        if (vpre[8] && sum >= int'(vth)) return {1'b1, 13'd0};
        return {1'b0, 13'(sum)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_state[i] = 13'd0;
        m_ts  = 0;
        m_ovr = 1'b0;
    endtask

    // Called in an IDLE cycle with a request offered; tick_at[k-1] pulses io_tick in cycle T+k.
    task automatic do_op(input logic [2:0] nid, input logic [8:0] vpre, input logic [12:0] vth,
                         input logic exp_spike, input logic [12:0] exp_state, input logic [3:0] tick_at);
        logic [12:0] prior;
        prior       = m_state[nid];
        io_in_valid = 1'b1;
        io_in_nid   = nid;
        io_in_vpre  = vpre;
        io_vth      = vth;
        io_tick     = 1'b0;
        #1;
        chk("ready_idle", 32'(io_in_ready), 32'd1);
        chk("vth_pass", 32'(io_dsn_vth), 32'(vth));
        step();
        io_in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            io_tick = tick_at[k-1];
            #1;
            chk("op_busy", 32'(io_busy), 32'd1);
            chk("op_ready", 32'(io_in_ready), 32'd0);
            chk("op_vpre", 32'(io_dsn_vpre), 32'(vpre));
            chk("op_vleak_in", 32'(io_dsn_vleak_in), 32'(prior));
            chk("op_no_spike", 32'(io_spike_valid), 32'd0);
            step();
        end
        io_tick = 1'b0;
        #1;
        if ($countones(tick_at) >= 2) m_ovr = 1'b1;
        chk("done_spike", 32'(io_spike_valid), 32'(exp_spike));
        if (exp_spike) chk("done_spike_nid", 32'(io_spike_nid), 32'(nid));
        chk("done_ready", 32'(io_in_ready), (tick_at == 4'd0) ? 32'd1 : 32'd0);
        chk("done_busy", 32'(io_busy), 32'd0);
        chk("done_vpre_zero", 32'(io_dsn_vpre), 32'd0);
        chk("done_state", 32'(dut.state_q[nid]), 32'(exp_state));
        chk("overrun", 32'(io_tick_overrun), 32'(m_ovr));
        m_state[nid] = exp_state;
    endtask

    // Called in an IDLE cycle from which LEAK starts at the next edge.
    task automatic leak_sweep();
        step();
        io_tick = 1'b0;
        #1;
        for (int c = 0; c < 8; c++) begin
            chk("leak_busy", 32'(io_busy), 32'd1);
            chk("leak_ready", 32'(io_in_ready), 32'd0);
            chk("leak_vpre", 32'(io_dsn_vpre), 32'd0);
            chk("leak_vleak_in", 32'(io_dsn_vleak_in), 32'd0);
            step();
        end
        for (int i = 0; i < 8; i++) m_state[i] = m_state[i] - m_state[i] / 8;
        m_ts = (m_ts + 1) % 256;
        chk("leak_end_busy", 32'(io_busy), 32'd0);
        for (int i = 0; i < 8; i++) chk("leak_state", 32'(dut.state_q[i]), 32'(m_state[i]));
        chk("timestep", 32'(io_timestep), 32'(m_ts));
        chk("leak_overrun", 32'(io_tick_overrun), 32'(m_ovr));
    endtask

    task automatic do_tick(input logic with_valid);
        io_tick     = 1'b1;
        io_in_valid = with_valid;
        #1;
        chk("tick_ready", 32'(io_in_ready), 32'd0);
        leak_sweep();
    endtask

    initial begin
        logic [13:0] p;
        logic [2:0]  r_nid;
        logic [8:0]  r_vpre;
        logic [12:0] r_vth;
        logic [3:0]  r_ta;
        int          sel;

        vecs[0] = '{3'd3, 9'h005, 13'd100, 1'b0, 13'd5};
        vecs[1] = '{3'd3, 9'h105, 13'd8,   1'b1, 13'd0};
        vecs[2] = '{3'd7, 9'h1FF, 13'd255, 1'b1, 13'd0};
        vecs[3] = '{3'd7, 9'h0FE, 13'd255, 1'b0, 13'd254};
        vecs[4] = '{3'd7, 9'h101, 13'd256, 1'b0, 13'd255};
        vecs[5] = '{3'd0, 9'h050, 13'd100, 1'b0, 13'd80};
        vecs[6] = '{3'd1, 9'h107, 13'd100, 1'b0, 13'd7};
        vecs[7] = '{3'd6, 9'h100, 13'd0,   1'b1, 13'd0};

        reset       = 1'b0;
        io_in_valid = 1'b1;
        io_in_nid   = 3'd2;
        io_in_vpre  = 9'h011;
        io_vth      = 13'd50;
        io_tick     = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_ready", 32'(io_in_ready), 32'd0);
        chk("rst_busy", 32'(io_busy), 32'd0);
        chk("rst_spike", 32'(io_spike_valid), 32'd0);
        chk("rst_spike_nid", 32'(io_spike_nid), 32'd0);
        chk("rst_vpre", 32'(io_dsn_vpre), 32'd0);
        chk("rst_vleak_in", 32'(io_dsn_vleak_in), 32'd0);
        chk("rst_timestep", 32'(io_timestep), 32'd0);
        chk("rst_overrun", 32'(io_tick_overrun), 32'd0);
        io_in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rel_ready", 32'(io_in_ready), 32'd1);

        // Directed table, applied back to back at full throughput.
        for (int v = 0; v < 8; v++) begin
            do_op(vecs[v].nid, vecs[v].vpre, vecs[v].vth, vecs[v].spike, vecs[v].state, 4'd0);
        end

        // Leak: state0 80->70, state1 7->7, state7 255->224.
        do_tick(1'b0);
        chk("leak_s0", 32'(dut.state_q[0]), 32'd70);
        chk("leak_s1", 32'(dut.state_q[1]), 32'd7);

        // Tick and request together: sweep first, request accepted right after.
        io_in_nid  = 3'd4;
        io_in_vpre = 9'h009;
        io_vth     = 13'd100;
        do_tick(1'b1);
        chk("post_leak_ready", 32'(io_in_ready), 32'd1);
        p = predict(3'd4, 9'h009, 13'd100);
        do_op(3'd4, 9'h009, 13'd100, p[13], p[12:0], 4'd0);

        // One tick during an op: sweep follows, no overrun.
        p = predict(3'd2, 9'h003, 13'd100);
        do_op(3'd2, 9'h003, 13'd100, p[13], p[12:0], 4'b0100);
        leak_sweep();

        // Two ticks during an op: overrun becomes sticky.
        p = predict(3'd2, 9'h103, 13'd2);
        do_op(3'd2, 9'h103, 13'd2, p[13], p[12:0], 4'b0011);
        leak_sweep();

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                do_tick(1'($urandom_range(0, 1)));
            end else begin
                r_nid  = 3'($urandom_range(0, 7));
                r_vpre = 9'($urandom);
                r_vth  = 13'($urandom_range(0, 700));
                r_ta   = (sel == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
                p = predict(r_nid, r_vpre, r_vth);
                do_op(r_nid, r_vpre, r_vth, p[13], p[12:0], r_ta);
                if (r_ta != 4'd0) leak_sweep();
            end
        end

        // Reset in cycle T+3 of an op that would otherwise spike.
        io_in_valid = 1'b1;
        io_in_nid   = 3'd5;
        io_in_vpre  = 9'h1AA;
        io_vth      = 13'd1;
        #1;
        chk("mid_ready", 32'(io_in_ready), 32'd1);
        step();
        io_in_valid = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_busy", 32'(io_busy), 32'd0);
        chk("mid_rst_ready", 32'(io_in_ready), 32'd0);
        chk("mid_rst_vpre", 32'(io_dsn_vpre), 32'd0);
        chk("mid_rst_vleak", 32'(io_dsn_vleak_in), 32'd0);
        chk("mid_rst_overrun", 32'(io_tick_overrun), 32'd0);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rel_ready", 32'(io_in_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("mid_no_spike", 32'(io_spike_valid), 32'd0);
            chk("mid_state5", 32'(dut.state_q[5]), 32'd0);
            step();
        end
        chk("mid_timestep", 32'(io_timestep), 32'd0);

        // Timestep wraps after 256 sweeps.
        for (int t = 0; t < 255; t++) do_tick(1'b0);
        chk("ts_255", 32'(io_timestep), 32'd255);
        do_tick(1'b0);
        chk("ts_wrap", 32'(io_timestep), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
